// File: rtl/softmax_div_feeder.sv
// softmax_div_feeder: buffers one node's exponentiated scores and their sum.
// It then streams (exp_i, sum) pairs into fxp_div_pipe, one pair per cycle.
// A tag pipeline matched to the divider latency qualifies the divider's
// un-handshaked output stream for the downstream consumer.
module softmax_div_feeder #(
  parameter int DW      = 16,
  parameter int DEPTH   = 16,
  parameter int CW      = 4,
  parameter int SUMW    = DW + CW,
  parameter int DIV_LAT = 19
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            in_last,
  output logic [DW:0]     div_dividend,
  output logic [SUMW:0]   div_divisor,
  output logic            div_valid,
  output logic            out_valid,
  output logic [CW-1:0]   out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            err_ovf
);

  typedef enum logic {ACCUM, ISSUE} state_t;

  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW:0] ONE_C   = (CW+1)'(1);

  state_t                        state_q, state_d;
  logic [CW:0]                   wr_cnt_q, wr_cnt_d;
  logic [CW:0]                   n_elem_q, n_elem_d;
  logic [CW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [SUMW-1:0]               sum_q, sum_d;
  logic                          err_ovf_q, err_ovf_d;
  logic [DW:0]                   dvd_q, dvd_d;
  logic [SUMW:0]                 dvs_q, dvs_d;
  logic                          div_valid_q, div_valid_d;
  logic [CW-1:0]                 tag_idx_q, tag_idx_d;
  logic                          tag_last_q, tag_last_d;
  logic [DIV_LAT-1:0]            pv_q, pv_d;
  logic [DIV_LAT-1:0][CW-1:0]    pidx_q, pidx_d;
  logic [DIV_LAT-1:0]            plast_q, plast_d;
  logic [DW-1:0]                 mem_q [DEPTH];

  logic                          hs;
  logic                          store;
  logic [SUMW:0]                 sum_ext;

  // Next-state logic for the accumulate/issue controller and its datapath
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    n_elem_d    = n_elem_q;
    rd_ptr_d    = rd_ptr_q;
    sum_d       = sum_q;
    err_ovf_d   = err_ovf_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    div_valid_d = 1'b0;
    tag_idx_d   = tag_idx_q;
    tag_last_d  = tag_last_q;

    hs      = in_valid && (state_q == ACCUM);
    store   = hs && (wr_cnt_q < DEPTH_C);
    // One extra bit catches overflow; it can only fire if DW grows without SUMW
    sum_ext = {1'b0, sum_q} + {{(SUMW+1-DW){1'b0}}, in_data};

    case (state_q)
      ACCUM: begin
        if (hs) begin
          if (store) begin
            wr_cnt_d = wr_cnt_q + ONE_C;
            sum_d    = sum_ext[SUMW] ? {SUMW{1'b1}} : sum_ext[SUMW-1:0];
          end else begin
            err_ovf_d = 1'b1;
          end
          if (in_last) begin
            state_d  = ISSUE;
            n_elem_d = store ? (wr_cnt_q + ONE_C) : wr_cnt_q;
            rd_ptr_d = '0;
          end
        end
      end
      ISSUE: begin
        dvd_d       = {1'b0, mem_q[rd_ptr_q]};
        // The divider must never see a zero divisor; an all-zero node divides by 1
        dvs_d       = {1'b0, (sum_q == '0) ? SUMW'(1) : sum_q};
        div_valid_d = 1'b1;
        tag_idx_d   = rd_ptr_q;
        tag_last_d  = ({1'b0, rd_ptr_q} == (n_elem_q - ONE_C));
        rd_ptr_d    = rd_ptr_q + 1'b1;
        if (tag_last_d) begin
          wr_cnt_d = '0;
          sum_d    = '0;
          state_d  = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    pv_d    = {pv_q[DIV_LAT-2:0], div_valid_q};
    pidx_d  = {pidx_q[DIV_LAT-2:0], tag_idx_q};
    plast_d = {plast_q[DIV_LAT-2:0], div_valid_q & tag_last_q};
  end

  // Controller, divider-facing registers and tag pipeline; reset flushes everything in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ACCUM;
      wr_cnt_q    <= '0;
      n_elem_q    <= '0;
      rd_ptr_q    <= '0;
      sum_q       <= '0;
      err_ovf_q   <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      div_valid_q <= 1'b0;
      tag_idx_q   <= '0;
      tag_last_q  <= 1'b0;
      pv_q        <= '0;
      pidx_q      <= '0;
      plast_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      n_elem_q    <= n_elem_d;
      rd_ptr_q    <= rd_ptr_d;
      sum_q       <= sum_d;
      err_ovf_q   <= err_ovf_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      div_valid_q <= div_valid_d;
      tag_idx_q   <= tag_idx_d;
      tag_last_q  <= tag_last_d;
      pv_q        <= pv_d;
      pidx_q      <= pidx_d;
      plast_q     <= plast_d;
    end
  end

  // Element buffer; contents are don't-care after reset so it carries no reset
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_cnt_q[CW-1:0]] <= in_data;
  end

  assign in_ready     = (state_q == ACCUM);
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign div_valid    = div_valid_q;
  assign out_valid    = pv_q[DIV_LAT-1];
  assign out_idx      = pidx_q[DIV_LAT-1];
  assign out_last     = plast_q[DIV_LAT-1];
  assign busy         = (state_q == ISSUE) || div_valid_q || (|pv_q);
  assign err_ovf      = err_ovf_q;

endmodule

// File: tb/tb_softmax_div_feeder.sv
// tb_softmax_div_feeder: directed test of the softmax divider feeder.
// Each node's issued pairs and output tags are logged with their cycle number,
// then compared against hand-computed values and timing.
module tb_softmax_div_feeder;

  localparam int DW      = 16;
  localparam int DEPTH   = 16;
  localparam int CW      = 4;
  localparam int SUMW    = DW + CW;
  localparam int DIV_LAT = 19;

  typedef struct {
    int              cyc;
    logic [DW:0]     dvd;
    logic [SUMW:0]   dvs;
  } pair_t;

  typedef struct {
    int              cyc;
    logic [CW-1:0]   idx;
    logic            last;
  } tag_t;

  logic            clk;
  logic            rstn;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            in_last;
  logic [DW:0]     div_dividend;
  logic [SUMW:0]   div_divisor;
  logic            div_valid;
  logic            out_valid;
  logic [CW-1:0]   out_idx;
  logic            out_last;
  logic            busy;
  logic            err_ovf;

  int              cyc = 0;
  int              busy_cnt = 0;
  int              last_busy = 0;
  int              ready_low_cnt = 0;
  pair_t           pairs[$];
  tag_t            tags[$];
  logic [DW-1:0]   exp_vals[$];

  int              n_tests = 0;
  int              n_fail = 0;

  softmax_div_feeder #(
    .DW(DW), .DEPTH(DEPTH), .CW(CW), .SUMW(SUMW), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .div_dividend(div_dividend),
    .div_divisor(div_divisor),
    .div_valid(div_valid),
    .out_valid(out_valid),
    .out_idx(out_idx),
    .out_last(out_last),
    .busy(busy),
    .err_ovf(err_ovf)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle stamp: equals the number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  // Log every issued pair, every qualified tag, and busy/ready activity, sampled mid-cycle
  always @(negedge clk) begin
    if (div_valid) pairs.push_back(pair_t'{cyc, div_dividend, div_divisor});
    if (out_valid) tags.push_back(tag_t'{cyc, out_idx, out_last});
    if (busy) begin
      busy_cnt  <= busy_cnt + 1;
      last_busy <= cyc;
    end
    if (!in_ready) ready_low_cnt <= ready_low_cnt + 1;
  end

  // Hard stop in case something wedges the whole run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one element and hold it until the feeder takes it; returns the handshake edge
  task automatic applyStimulus(input logic [DW-1:0] data, input logic last, output int hs_cyc);
    logic rdy;
    logic got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) got = 1'b1;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    hs_cyc   = cyc;
    checkOutput("handshake", 32'(got), 32'd1);
  endtask

  // Compare logged pairs starting at base against exp_vals, all with one divisor
  task automatic checkIssue(input string name, input int e_cyc, input int base, input logic [SUMW:0] exp_dvs);
    for (int i = 0; i < exp_vals.size(); i++) begin
      if (base + i < pairs.size()) begin
        checkOutput({name, "_pair_cyc"}, pairs[base+i].cyc, e_cyc + 1 + i);
        checkOutput({name, "_dividend"}, 32'(pairs[base+i].dvd), 32'({1'b0, exp_vals[i]}));
        checkOutput({name, "_divisor"},  32'(pairs[base+i].dvs), 32'(exp_dvs));
      end else begin
        checkOutput({name, "_pair_missing"}, pairs.size(), base + i + 1);
      end
    end
  endtask

  // Compare logged tags starting at base: idx counts up, last only on the final one
  task automatic checkTags(input string name, input int e_cyc, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      if (base + i < tags.size()) begin
        checkOutput({name, "_tag_cyc"}, tags[base+i].cyc, e_cyc + 1 + i + DIV_LAT);
        checkOutput({name, "_out_idx"}, 32'(tags[base+i].idx), i);
        checkOutput({name, "_out_last"}, 32'(tags[base+i].last), 32'(i == n - 1));
      end else begin
        checkOutput({name, "_tag_missing"}, tags.size(), base + i + 1);
      end
    end
  endtask

  // Directed sequence: reset, three-element node, single, all-zero, overflow, back-to-back, mid-issue reset
  initial begin
    int e, e_a, e_b, hs_b0, hs;
    int pb, tb, bb, rb;

    rstn     = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;

    #1 rstn = 1'b0;
    #1;
    checkOutput("rst_in_ready",  32'(in_ready), 32'd1);
    checkOutput("rst_div_valid", 32'(div_valid), 32'd0);
    checkOutput("rst_dividend",  32'(div_dividend), 32'd0);
    checkOutput("rst_divisor",   32'(div_divisor), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy",      32'(busy), 32'd0);
    checkOutput("rst_err_ovf",   32'(err_ovf), 32'd0);
    tick(2);
    rstn = 1'b1;
    tick(2);

    // Q8.8 node 1.0, 1.0, 2.0: sum 4.0 on every pair
    pb = pairs.size(); tb = tags.size(); bb = busy_cnt; rb = ready_low_cnt;
    applyStimulus(16'h0100, 1'b0, hs);
    applyStimulus(16'h0100, 1'b0, hs);
    applyStimulus(16'h0200, 1'b1, e);
    tick(DIV_LAT + 10);
    exp_vals = '{16'h0100, 16'h0100, 16'h0200};
    checkIssue("q88", e, pb, 21'h00400);
    checkTags("q88", e, tb, 3);
    checkOutput("q88_pair_count", pairs.size() - pb, 3);
    checkOutput("q88_tag_count", tags.size() - tb, 3);
    checkOutput("q88_ready_low", ready_low_cnt - rb, 3);
    checkOutput("q88_busy_cycles", busy_cnt - bb, DIV_LAT + 4);
    checkOutput("q88_busy_end", last_busy, e + 3 + DIV_LAT);
    checkOutput("q88_busy_idle", 32'(busy), 32'd0);

    // Single element: it is its own sum
    pb = pairs.size(); tb = tags.size();
    applyStimulus(16'h0080, 1'b1, e);
    tick(DIV_LAT + 10);
    exp_vals = '{16'h0080};
    checkIssue("single", e, pb, 21'h00080);
    checkTags("single", e, tb, 1);
    checkOutput("single_pair_count", pairs.size() - pb, 1);

    // All-zero node: divisor forced to 1
    pb = pairs.size(); tb = tags.size();
    for (int i = 0; i < 4; i++) applyStimulus(16'h0000, (i == 3), e);
    tick(DIV_LAT + 10);
    exp_vals = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    checkIssue("zero", e, pb, 21'h00001);
    checkTags("zero", e, tb, 4);

    // Seventeen elements into sixteen entries: the extra one is dropped and flagged
    pb = pairs.size(); tb = tags.size();
    for (int i = 0; i < 16; i++) applyStimulus(16'h0100, 1'b0, hs);
    checkOutput("ovf_not_yet", 32'(err_ovf), 32'd0);
    applyStimulus(16'h0100, 1'b1, e);
    checkOutput("ovf_set", 32'(err_ovf), 32'd1);
    tick(DIV_LAT + 25);
    exp_vals = {};
    for (int i = 0; i < 16; i++) exp_vals.push_back(16'h0100);
    checkIssue("ovf", e, pb, 21'h01000);
    checkTags("ovf", e, tb, 16);
    checkOutput("ovf_pair_count", pairs.size() - pb, 16);
    pb = pairs.size();
    applyStimulus(16'h0080, 1'b1, e);
    tick(DIV_LAT + 10);
    exp_vals = '{16'h0080};
    checkIssue("ovf_next", e, pb, 21'h00080);
    checkOutput("ovf_sticky", 32'(err_ovf), 32'd1);

    // Back-to-back: node B waits on in_ready through A's issue
    pb = pairs.size(); tb = tags.size(); bb = busy_cnt;
    applyStimulus(16'h0100, 1'b0, hs);
    applyStimulus(16'h0100, 1'b0, hs);
    applyStimulus(16'h0200, 1'b1, e_a);
    applyStimulus(16'h0300, 1'b0, hs_b0);
    applyStimulus(16'h0100, 1'b1, e_b);
    checkOutput("b2b_b_accept", hs_b0, e_a + 4);
    tick(DIV_LAT + 10);
    exp_vals = '{16'h0100, 16'h0100, 16'h0200};
    checkIssue("b2b_a", e_a, pb, 21'h00400);
    checkTags("b2b_a", e_a, tb, 3);
    exp_vals = '{16'h0300, 16'h0100};
    checkIssue("b2b_b", e_b, pb + 3, 21'h00400);
    checkTags("b2b_b", e_b, tb + 3, 2);
    checkOutput("b2b_tag_count", tags.size() - tb, 5);
    checkOutput("b2b_busy_cycles", busy_cnt - bb, (e_b - e_a) + DIV_LAT + 3);
    checkOutput("b2b_busy_end", last_busy, e_b + 2 + DIV_LAT);

    // Reset while the second pair of a four-element node is on the divider inputs
    for (int i = 0; i < 4; i++) applyStimulus(16'h0100, (i == 3), e);
    tick(2);
    checkOutput("mid_pre_valid", 32'(div_valid), 32'd1);
    checkOutput("mid_pre_divisor", 32'(div_divisor), 32'h00400);
    rstn = 1'b0;
    #1;
    checkOutput("mid_rst_div_valid", 32'(div_valid), 32'd0);
    checkOutput("mid_rst_dividend",  32'(div_dividend), 32'd0);
    checkOutput("mid_rst_divisor",   32'(div_divisor), 32'd0);
    checkOutput("mid_rst_busy",      32'(busy), 32'd0);
    checkOutput("mid_rst_in_ready",  32'(in_ready), 32'd1);
    checkOutput("mid_rst_err_ovf",   32'(err_ovf), 32'd0);
    #1 rstn = 1'b1;
    pb = pairs.size(); tb = tags.size();
    tick(DIV_LAT + 10);
    checkOutput("mid_no_pairs", pairs.size() - pb, 0);
    checkOutput("mid_no_tags", tags.size() - tb, 0);
    applyStimulus(16'h0080, 1'b1, e);
    tick(DIV_LAT + 10);
    exp_vals = '{16'h0080};
    checkIssue("post_rst", e, pb, 21'h00080);
    checkTags("post_rst", e, tb, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/softmax_div_feeder.md
Name: softmax_div_feeder

Overview:
- Upstream stage of the softmax fixed-point divider (fxp_div_pipe). Collects one node's exponentiated attention scores, accumulates their sum, then streams (exp_i, sum) pairs into the divider one per cycle.
- Carries a tag pipeline (valid/idx/last) matched to the divider latency, so the downstream consumer can qualify the un-handshaked divider output.
- Sits between the exp unit and fxp_div_pipe.

Parameters:
- DW, 16, width of an unsigned exp value.
- DEPTH, 16, maximum neighbours per node (buffer entries); power of two.
- CW, 4, log2(DEPTH); width of the index and count.
- SUMW, DW+CW, accumulator width.
- DIV_LAT, 19, divider latency in clock edges from input sample to output (WOI+WOF+3).

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- in_valid  in  1  exp value valid
- in_ready  out  1  feeder can accept
- in_data  in  DW  unsigned exp value
- in_last  in  1  final element of the node
- div_dividend  out  DW+1  to divider; zero-extended exp value
- div_divisor  out  SUMW+1  to divider; zero-extended sum
- div_valid  out  1  pair on div_* is meaningful
- out_valid  out  1  divider output this cycle is a real result
- out_idx  out  CW  element index of that result
- out_last  out  1  that result is the node's last
- busy  out  1  state==ISSUE or any tag in flight
- err_ovf  out  1  sticky: more than DEPTH elements received for a node

Interface rule (decided): reset rstn, asynchronous, active-low; clock clk.

Behaviour:
- Reset values: state=ACCUM; wr_cnt=0; rd_ptr=0; sum=0; all div_* outputs 0; tag pipeline all 0; err_ovf=0. Buffer contents are don't-care.
- ACCUM state:
  - in_ready=1.
  - On handshake (in_valid & in_ready) with wr_cnt<DEPTH: buf[wr_cnt]<=in_data, wr_cnt++, sum<=sat(sum+in_data).
  - If wr_cnt==DEPTH: element is accepted but dropped (not stored, not summed), and err_ovf<=1.
  - A handshake with in_last: go to ISSUE and set n_elem = stored count (always ≥1 unless dropped). rd_ptr=0.
- ISSUE state:
  - in_ready=0.
  - Each cycle registers div_dividend={1'b0,buf[rd_ptr]}, div_divisor={1'b0,sum or 1 if sum==0}, div_valid=1, tag_idx=rd_ptr, tag_last=(rd_ptr==n_elem-1); then rd_ptr++.
  - After the last pair is registered: clear wr_cnt and sum, return to ACCUM. On the next cycle div_valid=0 and div_* hold their last values.
- Zero-sum guard: a divisor of 0 is never driven; sum==0 is replaced by 1 (LSB).
- Saturation: sum clamps to all-ones if it would exceed SUMW bits. This can only occur if DW is widened without widening SUMW.
- Timing: if the in_last handshake occurs at edge E, pair i appears after edge E+1+i and is sampled by the divider at E+2+i.
- Tag pipeline: a DIV_LAT-deep shift register of {div_valid, tag_idx, tag_last}. out_valid/out_idx/out_last appear after edge E+1+i+DIV_LAT, coincident with divider result i.
- New node: accumulation may start in ACCUM while the previous node's tags are still in flight. busy stays 1 until the tag pipeline is empty.
- err_ovf is cleared only by reset.
- Reset mid-ISSUE aborts the node: no further div_valid; the tag pipeline is flushed so no stale out_valid appears.

Test Plan:
- Q8.8, inputs 0x0100, 0x0100, 0x0200 (last on third) -> div_divisor=0x00400 for three consecutive cycles; dividends 0x00100, 0x00100, 0x00200; out_valid high 3 cycles starting DIV_LAT edges after the first div_valid; out_idx 0,1,2; out_last only on idx 2; in_ready low for exactly 3 cycles.
- Single element 0x0080 with last -> one pair (0x00080, 0x00080); out_last=1, out_idx=0.
- All-zero inputs (0x0000 ×4, last) -> div_divisor=0x00001 on all four pairs.
- 17 elements of 0x0100 with DEPTH=16, last on 17th -> 16 pairs issued with sum 0x01000; err_ovf=1 and stays 1 through the next node.
- Back-to-back nodes: node B's first in_valid is held during node A's ISSUE -> B is accepted the cycle after A's last pair is registered. Tags for A and B are contiguous and correctly indexed; busy stays high until B's last out_valid.
- rstn pulsed low during the second issued pair of a 4-element node -> all outputs 0 asynchronously; no out_valid afterward; the next node is processed normally.
